// File: rtl/mult8x8_seq_ctrl.sv
// rtl/mult8x8_seq_ctrl.sv - 8x8 unsigned multiply sequenced over one shared 4x4 multiplier (optional MULT_ZERO_SKIP_EN)
module mult8x8_seq_ctrl #(
    parameter int HALF_W     = 4,
    parameter bit DONE_PULSE = 1'b1
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                start,
    input  logic [2*HALF_W-1:0] dataa,
    input  logic [2*HALF_W-1:0] datab,
    output logic [HALF_W-1:0]   mult_a,
    output logic [HALF_W-1:0]   mult_b,
    input  logic [2*HALF_W-1:0] mult_p,
    output logic [4*HALF_W-1:0] product,
    output logic                busy,
    output logic                done
);

    localparam int W  = 2 * HALF_W;
    localparam int PW = 4 * HALF_W;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t        state;
    state_t        state_nx;
    logic [1:0]    step;
    logic [W-1:0]  opa;
    logic [W-1:0]  opb;
    logic [PW-1:0] acc;
    logic [PW-1:0] shifted;
    logic [PW-1:0] sum;
    logic          accept;
    logic          zero_skip;
    logic          done_hold;

    // A new operation may be accepted in IDLE and in the single DONE cycle (back-to-back)
    assign accept = start && ((state == S_IDLE) || (state == S_DONE));

`ifdef MULT_ZERO_SKIP_EN
    assign zero_skip = (dataa == '0) || (datab == '0);
`else
    assign zero_skip = 1'b0;
`endif

    // Next state, nibble steering to the shared multiplier and partial-product alignment
    always_comb begin
        state_nx = state;
        mult_a   = '0;
        mult_b   = '0;
        shifted  = '0;
        case (state)
            S_IDLE: begin
                if (accept) state_nx = zero_skip ? S_DONE : S_CALC;
            end
            S_CALC: begin
                // step[0] selects the high nibble of A, step[1] the high nibble of B
                mult_a = step[0] ? opa[W-1:HALF_W] : opa[HALF_W-1:0];
                mult_b = step[1] ? opb[W-1:HALF_W] : opb[HALF_W-1:0];
                case (step)
                    2'd0:       shifted = {{W{1'b0}}, mult_p};
                    2'd1, 2'd2: shifted = {{HALF_W{1'b0}}, mult_p, {HALF_W{1'b0}}};
                    default:    shifted = {mult_p, {W{1'b0}}};
                endcase
                if (step == 2'd3) state_nx = S_DONE;
            end
            S_DONE: begin
                if (accept) state_nx = zero_skip ? S_DONE : S_CALC;
                else        state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
        // Final sum is at most 0xFE01, so the 16-bit add never carries out
        sum = acc + shifted;
    end

    // State register, operand latch, accumulator and result register
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state   <= S_IDLE;
            step    <= 2'd0;
            opa     <= '0;
            opb     <= '0;
            acc     <= '0;
            product <= '0;
        end else begin
            state <= state_nx;
            if (accept) begin
                opa  <= dataa;
                opb  <= datab;
                acc  <= '0;
                step <= 2'd0;
            end else if (state == S_CALC) begin
                acc  <= sum;
                step <= step + 2'd1;
            end
            if ((state == S_CALC) && (step == 2'd3)) begin
                product <= sum;
            end else if (accept && zero_skip) begin
                product <= '0;
            end
        end
    end

    // Held completion flag: set on DONE entry, cleared when the next start is accepted
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            done_hold <= 1'b0;
        end else if (state_nx == S_DONE) begin
            done_hold <= 1'b1;
        end else if (accept) begin
            done_hold <= 1'b0;
        end
    end

    assign busy = (state == S_CALC);
    assign done = DONE_PULSE ? (state == S_DONE) : done_hold;

endmodule

// File: tb/tb_mult8x8_seq_ctrl.sv
// tb/tb_mult8x8_seq_ctrl.sv - scoreboard bench for mult8x8_seq_ctrl (pulse and held done variants)
module tb_mult8x8_seq_ctrl;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic [7:0]  dataa;
    logic [7:0]  datab;

    logic [3:0]  mult_a0, mult_b0, mult_a1, mult_b1;
    logic [7:0]  mult_p0, mult_p1;
    logic [15:0] product0, product1;
    logic        busy0, busy1, done0, done1;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    typedef struct {
        logic [15:0] prod;
        int          cyc;
    } exp_t;

    exp_t sb[$];

    // Shared combinational 4x4 multipliers
    assign mult_p0 = {4'h0, mult_a0} * {4'h0, mult_b0};
    assign mult_p1 = {4'h0, mult_a1} * {4'h0, mult_b1};

    mult8x8_seq_ctrl #(.HALF_W(4), .DONE_PULSE(1'b1)) dut0 (
        .clk(clk), .reset_n(reset_n), .start(start), .dataa(dataa), .datab(datab),
        .mult_a(mult_a0), .mult_b(mult_b0), .mult_p(mult_p0),
        .product(product0), .busy(busy0), .done(done0)
    );

    mult8x8_seq_ctrl #(.HALF_W(4), .DONE_PULSE(1'b0)) dut1 (
        .clk(clk), .reset_n(reset_n), .start(start), .dataa(dataa), .datab(datab),
        .mult_a(mult_a1), .mult_b(mult_b1), .mult_p(mult_p1),
        .product(product1), .busy(busy1), .done(done1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (cyc %0d)", nm, act, exp, cyc);
        end
    endtask

    // Monitor: every done on the pulse variant pops one expected result
    always @(negedge clk) begin
        if (done0 === 1'b1) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_done: got done with product %h at cyc %0d, expected no done", product0, cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("product", {16'h0, product0}, {16'h0, e.prod});
                chk("done_cycle", cyc, e.cyc);
            end
        end
    end

    function automatic int latency(input logic [7:0] a, input logic [7:0] b);
`ifdef MULT_ZERO_SKIP_EN
        if (a == 8'h00 || b == 8'h00) return 1;
`endif
        return 5;
    endfunction

    task automatic drain();
        for (int i = 0; i < 20; i++) begin
            if (sb.size() == 0) break;
            @(posedge clk);
            #2;
        end
        chk("drain_pending", sb.size(), 0);
        sb.delete();
    endtask

    task automatic mul(input logic [7:0] a, input logic [7:0] b, input logic [15:0] p, input bit chk_busy);
        int lat;
        lat = latency(a, b);
        @(posedge clk);
        #1;
        start = 1'b1;
        dataa = a;
        datab = b;
        sb.push_back('{prod: p, cyc: cyc + lat});
        @(posedge clk);
        #1;
        start = 1'b0;
        if (chk_busy) begin
            for (int i = 1; i <= lat; i++) begin
                @(negedge clk);
                chk("busy_window", {31'h0, busy0}, {31'h0, (i < lat)});
            end
        end
        drain();
    endtask

    initial begin
        exp_t e;
        reset_n = 1'b0;
        start   = 1'b0;
        dataa   = 8'h00;
        datab   = 8'h00;

        // 1. reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_product", {16'h0, product0}, 32'h0);
        chk("rst_busy", {31'h0, busy0}, 32'h0);
        chk("rst_done", {31'h0, done0}, 32'h0);
        chk("rst_mult_a", {28'h0, mult_a0}, 32'h0);
        chk("rst_mult_b", {28'h0, mult_b0}, 32'h0);
        chk("rst_done_hold", {31'h0, done1}, 32'h0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;

        // 2. single multiplies
        mul(8'h03, 8'h04, 16'h000C, 1'b1);
        mul(8'hC6, 8'hAC, 16'h8508, 1'b0);
        mul(8'hFF, 8'hFF, 16'hFE01, 1'b0);

        // 3a. back-to-back with start held high
        @(posedge clk);
        #1;
        start = 1'b1;
        dataa = 8'hFF;
        datab = 8'hFF;
        sb.push_back('{prod: 16'hFE01, cyc: cyc + 5});
        repeat (5) @(posedge clk);
        #1;
        dataa = 8'h0E;
        datab = 8'h01;
        sb.push_back('{prod: 16'h000E, cyc: cyc + 5});
        @(posedge clk);
        #1;
        start = 1'b0;
        drain();

        // 3b. start pulsed while busy is ignored
        @(posedge clk);
        #1;
        start = 1'b1;
        dataa = 8'hC6;
        datab = 8'hAC;
        sb.push_back('{prod: 16'h8508, cyc: cyc + 5});
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        #1;
        start = 1'b1;
        dataa = 8'h11;
        datab = 8'h22;
        @(posedge clk);
        #1;
        start = 1'b0;
        dataa = 8'h00;
        datab = 8'h00;
        drain();
        repeat (6) @(posedge clk);
        #1;
        chk("ignored_start_product", {16'h0, product0}, 32'h8508);

        // 4. reset during step2 aborts; no done, product cleared
        @(posedge clk);
        #1;
        start = 1'b1;
        dataa = 8'hC6;
        datab = 8'hAC;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        chk("step2_mult_a", {28'h0, mult_a0}, 32'h6);
        chk("step2_mult_b", {28'h0, mult_b0}, 32'hA);
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        chk("abort_product", {16'h0, product0}, 32'h0);
        chk("abort_busy", {31'h0, busy0}, 32'h0);
        chk("abort_done", {31'h0, done0}, 32'h0);
        chk("abort_mult_a", {28'h0, mult_a0}, 32'h0);
        reset_n = 1'b1;
        repeat (8) @(posedge clk);
        mul(8'h0A, 8'h0C, 16'h0078, 1'b0);

        // 5. zero operand
        mul(8'h00, 8'h5A, 16'h0000, 1'b1);

        // 6. held done variant
        mul(8'h03, 8'h04, 16'h000C, 1'b0);
        chk("hold_product", {16'h0, product1}, 32'h000C);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("hold_done_idle", {31'h0, done1}, 32'h1);
        end
        @(posedge clk);
        #1;
        start = 1'b1;
        dataa = 8'h02;
        datab = 8'h02;
        sb.push_back('{prod: 16'h0004, cyc: cyc + 5});
        @(negedge clk);
        chk("hold_done_before_accept", {31'h0, done1}, 32'h1);
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("hold_done_cleared", {31'h0, done1}, 32'h0);
        drain();
        chk("hold_done_again", {31'h0, done1}, 32'h1);
        chk("hold_product2", {16'h0, product1}, 32'h0004);

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
